// File: rtl/dcr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dcr_pkg
//  Description : Shared types for the address-calc job sequencer: engine
//                codes, sequencer state encoding and an engine one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcr_pkg;

    typedef enum logic [1:0] {
        ENG_FFT = 2'd0,
        ENG_FIR = 2'd1,
        ENG_IIR = 2'd2,
        ENG_ILL = 2'd3
    } eng_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_N_ENG = 3;

    // Bit order {IIR, FIR, FFT}; the illegal code maps to no engine.
    function automatic logic [c_N_ENG-1:0] eng_onehot(input eng_t e);
        logic [c_N_ENG-1:0] v;
        v = '0;
        case (e)
            ENG_FFT: v = 3'b001;
            ENG_FIR: v = 3'b010;
            ENG_IIR: v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_calc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : addr_calc_ctrl_if
//  Description : Job command handshake, memory/engine flow-control inputs,
//                calculator controls (offset, filesize, enables, pauses) and
//                calculator done flags for the job sequencer.
//  Ports       : none (signal bundle only)
//  Modports    : slave  - the sequencer
//                master - the upstream/calculator side
//  Revision    : 1.0 - initial release
// ============================================================================
interface addr_calc_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_engine;
    logic [ADDR_W-1:0] cmd_offset;
    logic [ADDR_W-1:0] cmd_filesize;
    logic              mem_ready;
    logic              eng_in_ready;
    logic              eng_out_valid;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] filesize;
    logic              fft_enable, fir_enable, iir_enable;
    logic              fft_read_pause, fft_write_pause;
    logic              fir_read_pause, fir_write_pause;
    logic              iir_read_pause, iir_write_pause;
    logic              fft_read_done, fft_write_done;
    logic              fir_read_done, fir_write_done;
    logic              iir_read_done, iir_write_done;
    logic              busy;
    logic              job_done;
    logic              job_err;

    modport slave (
        input  cmd_valid, cmd_engine, cmd_offset, cmd_filesize,
        input  mem_ready, eng_in_ready, eng_out_valid,
        input  fft_read_done, fft_write_done, fir_read_done, fir_write_done,
        input  iir_read_done, iir_write_done,
        output cmd_ready, offset, filesize,
        output fft_enable, fir_enable, iir_enable,
        output fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause,
        output iir_read_pause, iir_write_pause,
        output busy, job_done, job_err
    );

    modport master (
        output cmd_valid, cmd_engine, cmd_offset, cmd_filesize,
        output mem_ready, eng_in_ready, eng_out_valid,
        output fft_read_done, fft_write_done, fir_read_done, fir_write_done,
        output iir_read_done, iir_write_done,
        input  cmd_ready, offset, filesize,
        input  fft_enable, fir_enable, iir_enable,
        input  fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause,
        input  iir_read_pause, iir_write_pause,
        input  busy, job_done, job_err
    );
endinterface
`default_nettype wire

// File: rtl/addr_calc_ctrl_dir_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dir_arbiter
//  Description : Combinational write-over-read grant for the shared address
//                bus and decode of the six calculator pause lines.
//  Ports       : i_active        grant allowed this cycle
//                i_eng           engine owning the job
//                i_eng_out_valid engine has write data
//                i_eng_in_ready  engine can take read data
//                i_mem_ready     memory accepts an address
//                i_rd_seen/i_wr_seen direction already finished
//                o_wr_grant/o_rd_grant granted direction (never both)
//                o_pause         {iir_w,iir_r,fir_w,fir_r,fft_w,fft_r}, 1=hold
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_arbiter
    import dcr_pkg::*;
(
    input  wire logic       i_active,
    input  wire eng_t       i_eng,
    input  wire logic       i_eng_out_valid,
    input  wire logic       i_eng_in_ready,
    input  wire logic       i_mem_ready,
    input  wire logic       i_rd_seen,
    input  wire logic       i_wr_seen,
    output logic            o_wr_grant,
    output logic            o_rd_grant,
    output logic [5:0]      o_pause
);
    always_comb begin
        o_wr_grant = i_active && i_eng_out_valid && i_mem_ready && !i_wr_seen;
        o_rd_grant = i_active && !o_wr_grant && i_eng_in_ready && i_mem_ready && !i_rd_seen;
        o_pause    = '1;
        case (i_eng)
            ENG_FFT: begin
                o_pause[0] = !o_rd_grant;
                o_pause[1] = !o_wr_grant;
            end
            ENG_FIR: begin
                o_pause[2] = !o_rd_grant;
                o_pause[3] = !o_wr_grant;
            end
            ENG_IIR: begin
                o_pause[4] = !o_rd_grant;
                o_pause[5] = !o_wr_grant;
            end
            default: o_pause = '1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/addr_calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addr_calc_ctrl
//  Description : Job sequencer in front of the address calculators. Accepts
//                one job per handshake, enables the chosen calculator, grants
//                the shared address bus to one direction per cycle and retires
//                the job once both read_done and write_done have been seen.
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    addr_calc_ctrl_if.slave (command, flow control,
//                       calculator controls and status)
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_calc_ctrl
    import dcr_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    addr_calc_ctrl_if.slave bus
);
    state_t            r_state;
    eng_t              r_eng;
    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] r_filesize;
    logic [2:0]        r_enable;
    logic [5:0]        r_pause;
    logic              r_busy, r_cmd_ready, r_job_done, r_job_err;
    logic              r_rd_seen, r_wr_seen;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_sel_rd_done, w_sel_wr_done;
    logic              w_rd_seen_nxt, w_wr_seen_nxt, w_new_done;
    logic              w_wr_grant, w_rd_grant;
    logic [5:0]        w_pause;
    logic [TO_W-1:0]   w_to_nxt;
    logic              w_timeout;
    eng_t              w_cmd_eng;

    assign w_cmd_eng = eng_t'(bus.cmd_engine);

    always_comb begin
        w_sel_rd_done = 1'b0;
        w_sel_wr_done = 1'b0;
        case (r_eng)
            ENG_FFT: begin w_sel_rd_done = bus.fft_read_done; w_sel_wr_done = bus.fft_write_done; end
            ENG_FIR: begin w_sel_rd_done = bus.fir_read_done; w_sel_wr_done = bus.fir_write_done; end
            ENG_IIR: begin w_sel_rd_done = bus.iir_read_done; w_sel_wr_done = bus.iir_write_done; end
            default: begin w_sel_rd_done = 1'b0; w_sel_wr_done = 1'b0; end
        endcase
    end

    // A done seen this cycle already blocks that direction in the registered
    // pause for the next cycle, so the grant looks at the updated flags.
    assign w_rd_seen_nxt = r_rd_seen | w_sel_rd_done;
    assign w_wr_seen_nxt = r_wr_seen | w_sel_wr_done;
    assign w_new_done    = (w_sel_rd_done & ~r_rd_seen) | (w_sel_wr_done & ~r_wr_seen);
    assign w_to_nxt      = r_to_cnt + 1'b1;
    assign w_timeout     = (TIMEOUT_CYC != 0) && (w_to_nxt == TO_W'(TIMEOUT_CYC));

    dir_arbiter u_dir_arbiter (
        .i_active        (r_state == ST_RUN),
        .i_eng           (r_eng),
        .i_eng_out_valid (bus.eng_out_valid),
        .i_eng_in_ready  (bus.eng_in_ready),
        .i_mem_ready     (bus.mem_ready),
        .i_rd_seen       (w_rd_seen_nxt),
        .i_wr_seen       (w_wr_seen_nxt),
        .o_wr_grant      (w_wr_grant),
        .o_rd_grant      (w_rd_grant),
        .o_pause         (w_pause)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_eng       <= ENG_FFT;
            r_offset    <= '0;
            r_filesize  <= '0;
            r_enable    <= '0;
            r_pause     <= '1;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_job_done  <= 1'b0;
            r_job_err   <= 1'b0;
            r_rd_seen   <= 1'b0;
            r_wr_seen   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_job_done <= 1'b0;
            r_job_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (w_cmd_eng == ENG_ILL) begin
                            r_job_err <= 1'b1;
                        end else if (bus.cmd_filesize == '0) begin
                            r_job_done <= 1'b1;
                        end else begin
                            r_eng       <= w_cmd_eng;
                            r_offset    <= bus.cmd_offset;
                            r_filesize  <= bus.cmd_filesize;
                            r_enable    <= eng_onehot(w_cmd_eng);
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                            r_rd_seen   <= 1'b0;
                            r_wr_seen   <= 1'b0;
                            r_to_cnt    <= '0;
                            r_state     <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_rd_seen <= w_rd_seen_nxt;
                    r_wr_seen <= w_wr_seen_nxt;
                    if (w_rd_seen_nxt && w_wr_seen_nxt) begin
                        r_enable   <= '0;
                        r_pause    <= '1;
                        r_job_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (w_new_done) begin
                        r_to_cnt <= '0;
                        r_pause  <= w_pause;
                    end else if (w_timeout) begin
                        r_enable    <= '0;
                        r_pause     <= '1;
                        r_job_err   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_to_cnt <= w_to_nxt;
                        r_pause  <= w_pause;
                    end
                end
                ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready       = r_cmd_ready;
    assign bus.offset          = r_offset;
    assign bus.filesize        = r_filesize;
    assign bus.fft_enable      = r_enable[0];
    assign bus.fir_enable      = r_enable[1];
    assign bus.iir_enable      = r_enable[2];
    assign bus.fft_read_pause  = r_pause[0];
    assign bus.fft_write_pause = r_pause[1];
    assign bus.fir_read_pause  = r_pause[2];
    assign bus.fir_write_pause = r_pause[3];
    assign bus.iir_read_pause  = r_pause[4];
    assign bus.iir_write_pause = r_pause[5];
    assign bus.busy            = r_busy;
    assign bus.job_done        = r_job_done;
    assign bus.job_err         = r_job_err;

    // Grant flags are folded into w_pause; kept visible for debug.
    logic w_unused;
    assign w_unused = w_wr_grant ^ w_rd_grant;
endmodule
`default_nettype wire

// File: tb/tb_addr_calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_calc_ctrl
//  Description : Randomized self-checking bench for addr_calc_ctrl with a
//                cycle-level behavioural reference model of the job rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_calc_ctrl;
    localparam int c_TO     = 16;
    localparam int c_CYCLES = 4000;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fails;

    addr_calc_ctrl_if #(.ADDR_W(32)) bus ();

    addr_calc_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(c_TO), .TO_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 start (calculators load), 2 run, 3 retire cycle
    int          m_phase;
    int          m_eng;
    bit          m_rd, m_wr;
    int          m_stall;
    bit          m_cmd_ready, m_busy, m_done, m_err;
    bit [2:0]    m_en;
    bit [5:0]    m_pause;
    bit [31:0]   m_off, m_fs;
    bit [2:0]    rd_d, wr_d;

    task automatic model_step();
        bit progress;
        if (!rst_n) begin
            m_phase = 0; m_eng = 0; m_rd = 0; m_wr = 0; m_stall = 0;
            m_cmd_ready = 1; m_busy = 0; m_done = 0; m_err = 0;
            m_en = 0; m_pause = '1; m_off = 0; m_fs = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        case (m_phase)
            0: if (bus.cmd_valid) begin
                if (bus.cmd_engine == 2'd3) m_err = 1;
                else if (bus.cmd_filesize == 0) m_done = 1;
                else begin
                    m_eng = int'(bus.cmd_engine);
                    m_off = bus.cmd_offset;
                    m_fs  = bus.cmd_filesize;
                    m_en  = 3'b001 << m_eng;
                    m_busy = 1; m_cmd_ready = 0;
                    m_rd = 0; m_wr = 0; m_stall = 0;
                    m_phase = 1;
                end
            end
            1: m_phase = 2;
            2: begin
                progress = (rd_d[m_eng] && !m_rd) || (wr_d[m_eng] && !m_wr);
                m_rd = m_rd | rd_d[m_eng];
                m_wr = m_wr | wr_d[m_eng];
                m_pause = '1;
                if (m_rd && m_wr) begin
                    m_en = 0; m_done = 1; m_phase = 3;
                end else begin
                    m_stall = progress ? 0 : m_stall + 1;
                    if (m_stall == c_TO) begin
                        m_en = 0; m_err = 1; m_busy = 0; m_cmd_ready = 1; m_phase = 0;
                    end else if (bus.mem_ready) begin
                        if (bus.eng_out_valid && !m_wr) m_pause[2*m_eng+1] = 0;
                        else if (bus.eng_in_ready && !m_rd) m_pause[2*m_eng] = 0;
                    end
                end
            end
            default: begin
                m_busy = 0; m_cmd_ready = 1; m_phase = 0;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        int mode;
        n_checks = 0;
        n_fails  = 0;
        rst_n = 0;
        bus.cmd_valid = 0; bus.cmd_engine = 0; bus.cmd_offset = 0; bus.cmd_filesize = 0;
        bus.mem_ready = 0; bus.eng_in_ready = 0; bus.eng_out_valid = 0;
        rd_d = 0; wr_d = 0;
        for (cyc = 0; cyc < c_CYCLES && n_fails < 30; cyc++) begin
            // modes: 0 sparse dones, 1 no dones (timeouts), 2 frequent dones, 3 memory stalls
            mode = (cyc / 250) % 4;
            rst_n = (cyc < 3) ? 1'b0 : ($urandom_range(0, 399) != 0);
            bus.cmd_valid    = $urandom_range(0, 1);
            bus.cmd_engine   = 2'($urandom_range(0, 3));
            bus.cmd_offset   = $urandom;
            bus.cmd_filesize = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            bus.mem_ready    = (mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.eng_in_ready = $urandom_range(0, 1);
            bus.eng_out_valid= $urandom_range(0, 1);
            for (int e = 0; e < 3; e++) begin
                case (mode)
                    1:       begin rd_d[e] = 0; wr_d[e] = 0; end
                    2:       begin rd_d[e] = ($urandom_range(0, 2) == 0); wr_d[e] = ($urandom_range(0, 2) == 0); end
                    default: begin rd_d[e] = ($urandom_range(0, 9) == 0); wr_d[e] = ($urandom_range(0, 9) == 0); end
                endcase
            end
            {bus.iir_read_done, bus.fir_read_done, bus.fft_read_done}    = rd_d;
            {bus.iir_write_done, bus.fir_write_done, bus.fft_write_done} = wr_d;
            model_step();
            @(negedge clk);
            check("cmd_ready", 64'(bus.cmd_ready), 64'(m_cmd_ready));
            check("busy",      64'(bus.busy),      64'(m_busy));
            check("job_done",  64'(bus.job_done),  64'(m_done));
            check("job_err",   64'(bus.job_err),   64'(m_err));
            check("enables",   64'({bus.iir_enable, bus.fir_enable, bus.fft_enable}), 64'(m_en));
            check("pauses",    64'({bus.iir_write_pause, bus.iir_read_pause,
                                    bus.fir_write_pause, bus.fir_read_pause,
                                    bus.fft_write_pause, bus.fft_read_pause}), 64'(m_pause));
            check("offset",    64'(bus.offset),    64'(m_off));
            check("filesize",  64'(bus.filesize),  64'(m_fs));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
